// File: rtl/drv_btn_multi_if.sv
// Handshake-free signal bundle between the button driver and its user.
//   en_i    : debounce/repeat tick enable
//   mode_i  : 00 rise, 01 fall, 10 both edges, 11 rise + auto-repeat
//   btn_i   : raw asynchronous button inputs, one bit per channel
//   level_o : debounced level per channel
//   pulse_o : one-clock event pulse per channel
//   any_o   : OR of all pulse bits, aligned with pulse_o
// master drives the inputs (control logic / bench); slave is the driver.
interface drv_btn_multi_if #(
    parameter int N_CH = 4
);
    logic            en_i;
    logic [1:0]      mode_i;
    logic [N_CH-1:0] btn_i;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] pulse_o;
    logic            any_o;

    modport master (
        output en_i, mode_i, btn_i,
        input  level_o, pulse_o, any_o
    );

    modport slave (
        input  en_i, mode_i, btn_i,
        output level_o, pulse_o, any_o
    );
endinterface

// File: rtl/drv_btn_multi.sv
// Multi-channel push-button driver.
// Each channel: SYNC_STAGES synchroniser, tick-gated counter debounce,
// mode-selected edge pulse and optional auto-repeat (mode 11).
// Ports:
//   clk_i : system clock, rising edge
//   rst_i : synchronous reset, active low
//   bus   : drv_btn_multi_if.slave (en_i, mode_i, btn_i, level_o, pulse_o, any_o)

// One button channel.
module drv_btn_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int DB_CNT      = 16,
    parameter int REP_DLY     = 500,
    parameter int REP_PER     = 100
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic       btn_i,
    output logic       level_o,
    output logic       pulse_o,
    output logic       pulse_nxt_o   // next-cycle pulse, lets the top register any_o aligned
);
    typedef enum logic {FIRST, REPEAT} phase_t;

    localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REP_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REP_PER - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_nxt;
    logic                   lvl_q, lvl_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic [CNT_W-1:0]       rcnt_q, rcnt_nxt;
    phase_t                 phase_q, phase_nxt;
    logic                   pulse_q, pulse_nxt;
    logic                   s;
    logic                   accept;
    logic [CNT_W-1:0]       rep_lim;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync_q  <= '0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            phase_q <= FIRST;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_nxt;
            lvl_q   <= lvl_nxt;
            cnt_q   <= cnt_nxt;
            rcnt_q  <= rcnt_nxt;
            phase_q <= phase_nxt;
            pulse_q <= pulse_nxt;
        end
    end

    always_comb begin
        sync_nxt  = {sync_q[SYNC_STAGES-2:0], btn_i};
        s         = sync_q[SYNC_STAGES-1];
        lvl_nxt   = lvl_q;
        cnt_nxt   = cnt_q;
        rcnt_nxt  = rcnt_q;
        phase_nxt = phase_q;
        pulse_nxt = 1'b0;
        accept    = 1'b0;
        rep_lim   = (phase_q == FIRST) ? DLY_LIM : PER_LIM;

        // Debounce: any agreement with the accepted level restarts the run.
        if (s == lvl_q) begin
            cnt_nxt = '0;
        end else if (en_i) begin
            if (cnt_q == DB_LIM) begin
                accept  = 1'b1;
                lvl_nxt = s;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end

        if (accept) begin
            // Rise pulses in 00/10/11, fall pulses in 01/10.
            pulse_nxt = s ? (mode_i != 2'b01) : (mode_i == 2'b01 || mode_i == 2'b10);
            rcnt_nxt  = '0;
            phase_nxt = FIRST;
        end else if (lvl_q && mode_i == 2'b11) begin
            if (en_i) begin
                if (rcnt_q == rep_lim) begin
                    pulse_nxt = 1'b1;
                    rcnt_nxt  = '0;
                    phase_nxt = REPEAT;
                end else begin
                    rcnt_nxt = rcnt_q + 1'b1;
                end
            end
        end else begin
            rcnt_nxt  = '0;
            phase_nxt = FIRST;
        end
    end

    assign level_o     = lvl_q;
    assign pulse_o     = pulse_q;
    assign pulse_nxt_o = pulse_nxt;
endmodule

module drv_btn_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int DB_CNT      = 16,
    parameter int REP_DLY     = 500,
    parameter int REP_PER     = 100
) (
    input  logic          clk_i,
    input  logic          rst_i,
    drv_btn_multi_if.slave bus
);
    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] pulse_w;
    logic [N_CH-1:0] pulse_d;
    logic            any_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        drv_btn_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .DB_CNT      (DB_CNT),
            .REP_DLY     (REP_DLY),
            .REP_PER     (REP_PER)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .en_i        (bus.en_i),
            .mode_i      (bus.mode_i),
            .btn_i       (bus.btn_i[g]),
            .level_o     (level_w[g]),
            .pulse_o     (pulse_w[g]),
            .pulse_nxt_o (pulse_d[g])
        );
    end

    // Built from the next-state pulses so any_o lands in the same cycle as pulse_o.
    always_ff @(posedge clk_i) begin
        if (!rst_i) any_q <= 1'b0;
        else        any_q <= |pulse_d;
    end

    assign bus.level_o = level_w;
    assign bus.pulse_o = pulse_w;
    assign bus.any_o   = any_q;
endmodule

// File: tb/tb_drv_btn_multi.sv
module tb_drv_btn_multi;
    localparam int NC = 2, SYNC = 2, DB = 4, RDLY = 8, RPER = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;

    drv_btn_multi_if #(.N_CH(NC)) bus();

    drv_btn_multi #(
        .N_CH(NC), .SYNC_STAGES(SYNC), .CNT_W(16),
        .DB_CNT(DB), .REP_DLY(RDLY), .REP_PER(RPER)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference model: delay line for the synchroniser, run length of
    // disagreeing ticks for debounce, ticks held since press for repeat.
    logic [NC-1:0] m_dly [SYNC];
    logic [NC-1:0] m_lvl = '0, m_pulse = '0;
    logic          m_any = 1'b0;
    int            m_run [NC];
    int            m_held[NC];

    task automatic model_edge();
        logic [NC-1:0] s, np;
        bit acc;
        if (!rst) begin
            for (int i = 0; i < SYNC; i++) m_dly[i] = '0;
            m_lvl = '0; m_pulse = '0; m_any = 1'b0;
            for (int c = 0; c < NC; c++) begin m_run[c] = 0; m_held[c] = 0; end
            return;
        end
        s  = m_dly[SYNC-1];
        np = '0;
        for (int c = 0; c < NC; c++) begin
            acc = 0;
            if (s[c] != m_lvl[c]) begin
                if (bus.en_i) m_run[c]++;
                if (m_run[c] == DB) begin acc = 1; m_run[c] = 0; end
            end else m_run[c] = 0;
            if (acc) begin
                m_lvl[c]  = s[c];
                np[c]     = s[c] ? (bus.mode_i != 2'd1) : (bus.mode_i == 2'd1 || bus.mode_i == 2'd2);
                m_held[c] = 0;
            end else if (m_lvl[c] && bus.mode_i == 2'd3) begin
                if (bus.en_i) begin
                    m_held[c]++;
                    if (m_held[c] == RDLY || (m_held[c] > RDLY && (m_held[c] - RDLY) % RPER == 0))
                        np[c] = 1'b1;
                end
            end else m_held[c] = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = bus.btn_i;
        m_pulse  = np;
        m_any    = |np;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        int first = -1;
        logic lvl_at = 1'b0, any_at = 1'b0;
        rst = 1'b0; bus.btn_i = 2'b01; bus.en_i = 1'b1; bus.mode_i = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== 5'b0) begin
                bad++; $display("FAIL reset_hold cyc=%0d got=%b exp=00000", cyc, {bus.level_o, bus.pulse_o, bus.any_o});
            end
        end
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            if (bus.pulse_o[0] && first < 0) begin first = i; lvl_at = bus.level_o[0]; any_at = bus.any_o; end
        end
        total++;
        if (first != 6 || lvl_at !== 1'b1 || any_at !== 1'b1) begin
            bad++; $display("FAIL reset_reacquire edge=%0d lvl=%b any=%b exp edge=6 lvl=1 any=1", first, lvl_at, any_at);
        end
    endtask

    task automatic test_press_release();
        int fall = -1, rise = -1, np0 = 0, np1 = 0;
        bus.mode_i = 2'd0;
        bus.btn_i = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL press_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            if (!bus.level_o[0] && fall < 0) fall = i;
            np0 += int'(bus.pulse_o[0]);
        end
        total++;
        if (fall != 6 || np0 != 0) begin
            bad++; $display("FAIL release_mode00 fall_edge=%0d pulses=%0d exp 6/0", fall, np0);
        end
        bus.btn_i = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL press_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            if (bus.pulse_o[0] && rise < 0) rise = i;
            np1 += int'(bus.pulse_o[0]);
        end
        total++;
        if (rise != 6 || np1 != 1) begin
            bad++; $display("FAIL press_mode00 pulse_edge=%0d pulses=%0d exp 6/1", rise, np1);
        end
        bus.btn_i = 2'b00;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_bounce();
        int pat[8] = '{1, 1, 1, 0, 1, 1, 0, 1};
        int pe = -1, lr = -1, np = 0;
        bus.mode_i = 2'd0;
        for (int i = 0; i < 20; i++) begin
            bus.btn_i[0] = (i < 8) ? pat[i][0] : 1'b1;
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            if (bus.pulse_o[0]) begin np++; if (pe < 0) pe = i + 1; end
            if (bus.level_o[0] && lr < 0) lr = i + 1;
        end
        total++;
        if (np != 1 || pe != 13 || lr != 13) begin
            bad++; $display("FAIL bounce pulses=%0d pulse_edge=%0d level_edge=%0d exp 1/13/13", np, pe, lr);
        end
        bus.btn_i = 2'b00;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_both_edges();
        int p0 = 0, p1 = 0;
        bus.mode_i = 2'd2;
        for (int i = 0; i < 20; i++) begin
            bus.btn_i = (i < 10) ? 2'b10 : 2'b00;
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL both_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            p0 += int'(bus.pulse_o[0]);
            p1 += int'(bus.pulse_o[1]);
        end
        total++;
        if (p1 != 2 || p0 != 0) begin
            bad++; $display("FAIL both_edges ch1=%0d ch0=%0d exp 2/0", p1, p0);
        end
    endtask

    task automatic test_repeat();
        int exp_rel[6] = '{8, 11, 14, 17, 20, 23};
        int got[$];
        int t = -1, after = 0;
        bit fell = 0;
        bus.mode_i = 2'd3;
        bus.btn_i  = 2'b01;
        for (int i = 1; i <= 10 && t < 0; i++) begin
            step();
            if (bus.pulse_o[0]) t = i;
        end
        total++;
        if (t != 6) begin bad++; $display("FAIL repeat_press edge=%0d exp=6", t); end
        for (int k = 1; k <= 25; k++) begin
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL repeat_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            if (bus.pulse_o[0]) got.push_back(k);
        end
        total++;
        if (got.size() != 6) begin
            bad++; $display("FAIL repeat_count got=%0d exp=6", got.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                total++;
                if (got[j] != exp_rel[j]) begin
                    bad++; $display("FAIL repeat_time idx=%0d got=T+%0d exp=T+%0d", j, got[j], exp_rel[j]);
                end
            end
        end
        bus.btn_i = 2'b00;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL repeat_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            if (fell) after += int'(bus.pulse_o[0]);
            if (!bus.level_o[0]) fell = 1;
        end
        total++;
        if (!fell || after != 0) begin
            bad++; $display("FAIL repeat_release fell=%0d pulses_after=%0d exp 1/0", fell, after);
        end
    endtask

    task automatic test_mode_change();
        int np = 0;
        bit lvl_ok = 1;
        bus.mode_i = 2'd0;
        bus.btn_i  = 2'b01;
        for (int i = 0; i < 10; i++) step();
        for (int m = 1; m <= 4; m++) begin
            bus.mode_i = 2'(m % 4);
            for (int i = 0; i < 3; i++) begin
                step();
                total++;
                if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                    bad++; $display("FAIL mode_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
                end
                np += int'(bus.pulse_o[0]);
                if (bus.level_o[0] !== 1'b1) lvl_ok = 0;
            end
        end
        total++;
        if (np != 0 || !lvl_ok) begin
            bad++; $display("FAIL mode_change pulses=%0d level_held=%0d exp 0/1", np, lvl_ok);
        end
        bus.btn_i = 2'b00;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_slow_tick();
        int gp = 0, ev = 0;
        logic [NC-1:0] pv = '0;
        logic av = 1'b0;
        bus.mode_i = 2'd0;
        for (int i = 0; i < 36; i++) begin
            bus.en_i  = (cyc % 4 == 0);
            bus.btn_i = (i < 6) ? 2'b11 : 2'b00;
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL slow_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            gp += int'(bus.any_o) + int'(bus.pulse_o != '0);
        end
        total++;
        if (gp != 0) begin bad++; $display("FAIL slow_glitch pulses=%0d exp=0", gp); end
        bus.btn_i = 2'b11;
        for (int i = 0; i < 60; i++) begin
            bus.en_i = (cyc % 4 == 0);
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL slow_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            if (bus.pulse_o != '0) begin ev++; pv = bus.pulse_o; av = bus.any_o; end
        end
        total++;
        if (ev != 1 || pv !== 2'b11 || av !== 1'b1) begin
            bad++; $display("FAIL slow_simul events=%0d pulse=%b any=%b exp 1/11/1", ev, pv, av);
        end
        bus.btn_i = 2'b00;
        for (int i = 0; i < 60; i++) begin bus.en_i = (cyc % 4 == 0); step(); end
        bus.en_i = 1'b1;
    endtask

    task automatic test_random();
        int npulse = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++)
                if ($urandom_range(0, 11) == 0) bus.btn_i[c] = ~bus.btn_i[c];
            bus.en_i = (i < 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) bus.mode_i = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) != 0);
            step();
            total++;
            if ({bus.level_o, bus.pulse_o, bus.any_o} !== {m_lvl, m_pulse, m_any}) begin
                bad++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {bus.level_o, bus.pulse_o, bus.any_o}, {m_lvl, m_pulse, m_any});
            end
            npulse += int'(m_any);
        end
        rst = 1'b1;
        total++;
        if (npulse == 0) begin bad++; $display("FAIL random_activity pulses=%0d exp>0", npulse); end
    endtask

    initial begin
        bus.en_i = 1'b1; bus.mode_i = 2'd0; bus.btn_i = '0;
        for (int c = 0; c < NC; c++) begin m_run[c] = 0; m_held[c] = 0; end
        for (int i = 0; i < SYNC; i++) m_dly[i] = '0;
        test_reset();
        test_press_release();
        test_bounce();
        test_both_edges();
        test_repeat();
        test_mode_change();
        test_slow_tick();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
